// File: rtl/hacd_comp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hacd_comp_pkg
// Description : Shared definitions for the page compressor and decompressor:
//               page geometry, metadata line layout, FSM state encoding and
//               helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 512
`endif

package hacd_comp_pkg;

    // Page geometry: 4 chunks of 16 lines of 64 bytes = one 4 KB page.
    localparam int LINES_PER_CHUNK = 16;
    localparam int NUM_CHUNKS      = 4;
    localparam int LINE_BYTES      = 64;
    localparam int LINES_PER_PAGE  = LINES_PER_CHUNK * NUM_CHUNKS;
    localparam int DATA_WIDTH      = `HACD_AXI4_DATA_WIDTH;
    localparam int LINE_IDX_W      = $clog2(LINES_PER_PAGE);
    localparam int CHUNK_IDX_W     = $clog2(NUM_CHUNKS);

    // Metadata line: zero_chunk_vec sits in the low bits, everything else 0.
    localparam int META_ZVEC_LSB = 0;
    localparam int META_ZVEC_MSB = META_ZVEC_LSB + NUM_CHUNKS - 1;

    // Compressor FSM encoding.
    typedef logic [2:0] comp_state_t;
    localparam comp_state_t ST_IDLE      = 3'd0;
    localparam comp_state_t ST_SCAN      = 3'd1;
    localparam comp_state_t ST_META      = 3'd2;
    localparam comp_state_t ST_LD_RDPTR  = 3'd3;
    localparam comp_state_t ST_XFER      = 3'd4;
    localparam comp_state_t ST_DONE      = 3'd5;
    localparam comp_state_t ST_BUS_ERROR = 3'd6;

    // Compressed size: one metadata line plus 16 lines per non-zero chunk.
    function automatic logic [13:0] comp_size_bytes(input logic [NUM_CHUNKS-1:0] zvec);
        logic [13:0] n;
        n = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (!zvec[i]) n = n + 14'd1;
        end
        return 14'(LINE_BYTES) + n * 14'(LINE_BYTES * LINES_PER_CHUNK);
    endfunction

    // Index of the lowest clear bit (caller guarantees one exists).
    function automatic logic [CHUNK_IDX_W-1:0] lowest_pending(input logic [NUM_CHUNKS-1:0] done_mask);
        logic [CHUNK_IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CHUNKS - 1; i >= 0; i--) begin
            if (!done_mask[i]) idx = CHUNK_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/compressor_if.sv
`default_nettype none
// ============================================================================
// Module      : compressor_if
// Description : Control, read-FIFO and write-FIFO signals of the page
//               compressor. master = compressor, slave = FIFO/controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface compressor_if
    import hacd_comp_pkg::*;
#(
    parameter int FIFO_PTR_WIDTH = 6
);
    logic                      comp_start;
    logic [13:0]               comp_size;
    logic                      comp_fail;
    logic                      comp_done;
    logic [FIFO_PTR_WIDTH-1:0] rdfifo_rdptr;
    logic                      ld_rdfifo_rdptr;
    logic                      rdfifo_empty;
    logic                      rd_req;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic [1:0]                rd_rresp;
    logic                      rd_valid;
    logic                      wrfifo_full;
    logic                      wr_req;
    logic [DATA_WIDTH-1:0]     wr_data;

    modport master (
        input  comp_start, rdfifo_empty, rd_data, rd_rresp, rd_valid, wrfifo_full,
        output comp_size, comp_fail, comp_done, rdfifo_rdptr, ld_rdfifo_rdptr,
               rd_req, wr_req, wr_data
    );

    modport slave (
        output comp_start, rdfifo_empty, rd_data, rd_rresp, rd_valid, wrfifo_full,
        input  comp_size, comp_fail, comp_done, rdfifo_rdptr, ld_rdfifo_rdptr,
               rd_req, wr_req, wr_data
    );
endinterface

`default_nettype wire

// File: rtl/comp_zero_scan.sv
`default_nettype none
// ============================================================================
// Module      : comp_zero_scan
// Description : Zero-line detection and zero_chunk_vec accumulation. Every
//               chunk starts out presumed all-zero; any non-zero line clears
//               the bit of the chunk it belongs to.
// Revision    : 1.0 - initial release
// ============================================================================
module comp_zero_scan
    import hacd_comp_pkg::*;
(
    input  wire logic                   clk_i,
    input  wire logic                   rst_ni,
    input  wire logic                   clear,
    input  wire logic                   line_valid,
    input  wire logic [CHUNK_IDX_W-1:0] chunk_idx,
    input  wire logic [DATA_WIDTH-1:0]  line_data,
    output logic      [NUM_CHUNKS-1:0]  zero_chunk_vec,
    output logic      [NUM_CHUNKS-1:0]  zero_chunk_vec_next
);
    logic [NUM_CHUNKS-1:0] r_zvec;
    logic [NUM_CHUNKS-1:0] w_zvec_next;

    // Next vector: restart on clear, otherwise knock out chunks with data.
    always_comb begin
        w_zvec_next = r_zvec;
        if (clear) begin
            w_zvec_next = '1;
        end else if (line_valid && (|line_data)) begin
            w_zvec_next[chunk_idx] = 1'b0;
        end
    end

    // Vector register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_zvec <= '1;
        end else begin
            r_zvec <= w_zvec_next;
        end
    end

    assign zero_chunk_vec      = r_zvec;
    assign zero_chunk_vec_next = w_zvec_next;
endmodule

`default_nettype wire

// File: rtl/compressor.sv
`default_nettype none
// ============================================================================
// Module      : compressor
// Description : Zero-chunk page compressor. Scans the 64-line page in the
//               read FIFO, writes a metadata line holding zero_chunk_vec,
//               then replays every non-zero 16-line chunk in ascending order.
//               Optional macro COMP_INCOMPRESSIBLE_ABORT_EN: a page with no
//               all-zero chunk is abandoned (comp_fail, nothing written).
// Revision    : 1.0 - initial release
// ============================================================================
module compressor
    import hacd_comp_pkg::*;
#(
    parameter int FIFO_PTR_WIDTH = 6
)(
    input wire logic      clk_i,
    input wire logic      rst_ni,
    compressor_if.master  bus
);
    comp_state_t               r_state;
    logic                      r_outstanding;
    logic [LINE_IDX_W-1:0]     r_line_cnt;
    logic [NUM_CHUNKS-1:0]     r_sent;
    logic [CHUNK_IDX_W-1:0]    r_cur_chunk;
    logic                      r_ld;
    logic [FIFO_PTR_WIDTH-1:0] r_ptr;
    logic                      r_wr_pend;
    logic [DATA_WIDTH-1:0]     r_wr_data;
    logic                      r_abort;

    logic                      w_line_ok;
    logic                      w_rd_err;
    logic                      w_rd_req;
    logic                      w_scan_clear;
    logic                      w_scan_valid;
    logic [NUM_CHUNKS-1:0]     w_zvec;
    logic [NUM_CHUNKS-1:0]     w_zvec_next;
    logic [NUM_CHUNKS-1:0]     w_sent_next;
    logic [DATA_WIDTH-1:0]     w_meta_line;

    assign w_line_ok    = r_outstanding && bus.rd_valid && (bus.rd_rresp == 2'b00);
    assign w_rd_err     = bus.rd_valid && (bus.rd_rresp != 2'b00);
    assign w_scan_clear = (r_state == ST_IDLE) && bus.comp_start;
    assign w_scan_valid = (r_state == ST_SCAN) && w_line_ok;
    assign w_sent_next  = r_sent | (NUM_CHUNKS'(1) << r_cur_chunk);

    comp_zero_scan u_zero_scan (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .clear               (w_scan_clear),
        .line_valid          (w_scan_valid),
        .chunk_idx           (r_line_cnt[LINE_IDX_W-1 -: CHUNK_IDX_W]),
        .line_data           (bus.rd_data),
        .zero_chunk_vec      (w_zvec),
        .zero_chunk_vec_next (w_zvec_next)
    );

    // Metadata line: zero_chunk_vec in the low bits, the rest zero.
    always_comb begin
        w_meta_line = '0;
        w_meta_line[META_ZVEC_MSB:META_ZVEC_LSB] = w_zvec;
    end

    // Read request: one outstanding at most, never in the pointer-load cycle,
    // and during replay only when the write side can take the line.
    always_comb begin
        w_rd_req = 1'b0;
        if (!r_outstanding && !r_ld && !bus.rdfifo_empty) begin
            case (r_state)
                ST_SCAN: w_rd_req = 1'b1;
                ST_XFER: w_rd_req = !bus.wrfifo_full && !r_wr_pend;
                default: w_rd_req = 1'b0;
            endcase
        end
    end

    // Main sequencer: scan, metadata, per-chunk pointer load and replay.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_IDLE;
            r_outstanding <= 1'b0;
            r_line_cnt    <= '0;
            r_sent        <= '0;
            r_cur_chunk   <= '0;
            r_ld          <= 1'b0;
            r_ptr         <= '0;
            r_wr_pend     <= 1'b0;
            r_wr_data     <= '0;
            r_abort       <= 1'b0;
        end else begin
            r_ld <= 1'b0;
            if (w_rd_req) begin
                r_outstanding <= 1'b1;
            end else if (bus.rd_valid) begin
                r_outstanding <= 1'b0;
            end
            if (bus.wr_req) begin
                r_wr_pend <= 1'b0;
            end

            if (w_rd_err) begin
                r_state       <= ST_BUS_ERROR;
                r_outstanding <= 1'b0;
                r_wr_pend     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.comp_start) begin
                            r_ld       <= 1'b1;
                            r_ptr      <= '0;
                            r_line_cnt <= '0;
                            r_sent     <= '0;
                            r_abort    <= 1'b0;
                            r_state    <= ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        if (w_line_ok) begin
                            if (r_line_cnt == LINE_IDX_W'(LINES_PER_PAGE - 1)) begin
`ifdef COMP_INCOMPRESSIBLE_ABORT_EN
                                if (w_zvec_next == '0) begin
                                    r_abort <= 1'b1;
                                    r_state <= ST_DONE;
                                end else begin
                                    r_state <= ST_META;
                                end
`else
                                r_state <= ST_META;
`endif
                            end else begin
                                r_line_cnt <= r_line_cnt + 1'b1;
                            end
                        end
                    end
                    ST_META: begin
                        if (!bus.wrfifo_full && !r_wr_pend) begin
                            r_wr_pend <= 1'b1;
                            r_wr_data <= w_meta_line;
                            r_state   <= (w_zvec == '1) ? ST_DONE : ST_LD_RDPTR;
                        end
                    end
                    ST_LD_RDPTR: begin
                        r_cur_chunk <= lowest_pending(w_zvec | r_sent);
                        r_ptr       <= FIFO_PTR_WIDTH'({lowest_pending(w_zvec | r_sent), 4'b0000});
                        r_ld        <= 1'b1;
                        r_line_cnt  <= '0;
                        r_state     <= ST_XFER;
                    end
                    ST_XFER: begin
                        if (w_line_ok) begin
                            r_wr_pend <= 1'b1;
                            r_wr_data <= bus.rd_data;
                            if (r_line_cnt == LINE_IDX_W'(LINES_PER_CHUNK - 1)) begin
                                r_sent  <= w_sent_next;
                                r_state <= ((w_zvec | w_sent_next) == '1) ? ST_DONE : ST_LD_RDPTR;
                            end else begin
                                r_line_cnt <= r_line_cnt + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (!bus.comp_start && !r_wr_pend) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_BUS_ERROR: begin
                        r_state <= ST_BUS_ERROR;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // A pending line leaves as soon as the write FIFO has room; completion
    // is only reported once the final line has left.
    assign bus.rd_req          = w_rd_req;
    assign bus.wr_req          = r_wr_pend && !bus.wrfifo_full;
    assign bus.wr_data         = r_wr_data;
    assign bus.ld_rdfifo_rdptr = r_ld;
    assign bus.rdfifo_rdptr    = r_ptr;
    assign bus.comp_done       = ((r_state == ST_DONE) && !r_wr_pend) || (r_state == ST_BUS_ERROR);
    assign bus.comp_fail       = (r_state == ST_BUS_ERROR) || ((r_state == ST_DONE) && r_abort);
    assign bus.comp_size       = ((r_state == ST_DONE) && !r_abort && !r_wr_pend)
                                 ? comp_size_bytes(w_zvec) : 14'd0;
endmodule

`default_nettype wire
